// File: rtl/gomoku_ui_pkg.sv
// Shared types and board geometry for the Gomoku UI datapath.
// Cell encoding, read-pipeline tags and clear-FSM states live here.
package gomoku_ui_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BLACK = 2'b01,
        WHITE = 2'b10
    } cell_t;

    localparam int BOARD_N = 15;
    localparam int CELLS   = BOARD_N * BOARD_N;
    localparam int ADDR_W  = 8;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_VGA  = 2'd1,
        TAG_GAME = 2'd2,
        TAG_ERR  = 2'd3
    } rd_tag_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/board_mem_arbiter_clear_seq.sv
// Full-board clear sequencer: walks addresses 0..CELLS-1, advancing only
// on cycles the arbiter grants to it.
module board_clear_seq #(
    parameter int CELLS  = gomoku_ui_pkg::CELLS,
    parameter int ADDR_W = gomoku_ui_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              grant,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr
);
    import gomoku_ui_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              last_wr;

    assign last_wr = (state_q == CLR_RUN) && grant && (cnt_q == LAST_ADDR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLR_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CLR_IDLE: if (start)   state_d = CLR_RUN;
            CLR_RUN:  if (last_wr) state_d = CLR_IDLE;
            default:               state_d = CLR_IDLE;
        endcase
    end

    // Counter only moves on granted slots so VGA steals never skip a cell.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == CLR_IDLE) begin
            cnt_d = '0;
        end else if (grant) begin
            cnt_d = last_wr ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        busy = (state_q == CLR_RUN);
        done = last_wr;
        addr = cnt_q;
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: VGA reads > clear writes > game port,
// with a two-stage tag pipeline routing read data back to its requester.
module board_mem_arbiter #(
    parameter int CELLS  = gomoku_ui_pkg::CELLS,
    parameter int ADDR_W = gomoku_ui_pkg::ADDR_W,
    parameter int DATA_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_en,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_data_valid,
    input  logic              game_valid,
    output logic              game_ready,
    input  logic              game_we,
    input  logic [ADDR_W-1:0] game_addr,
    input  logic [DATA_W-1:0] game_wdata,
    output logic [DATA_W-1:0] game_rdata,
    output logic              game_rvalid,
    output logic              game_err,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import gomoku_ui_pkg::*;

    localparam logic [ADDR_W:0] CELLS_X = (ADDR_W + 1)'(CELLS);

    logic              vga_slot, clr_slot, game_acc, game_in_rng;
    logic              clr_busy, clr_done;
    logic [ADDR_W-1:0] clr_addr;
    rd_tag_t           tag_p0;
    rd_tag_t           tag_p1_q, tag_p1_d;
    logic              game_err_q, game_err_d;
    logic [DATA_W-1:0] vga_data_q, vga_data_d;
    logic              vga_vld_q, vga_vld_d;
    logic [DATA_W-1:0] game_rdata_q, game_rdata_d;
    logic              game_vld_q, game_vld_d;

    // Combinational grants are masked by rst_n so every output is 0 in reset.
    assign vga_slot    = rst_n && pix_en && vga_req;
    assign clr_slot    = rst_n && !vga_slot && clr_busy;
    assign game_ready  = rst_n && !vga_slot && !clr_busy && !clear_start;
    assign game_acc    = game_valid && game_ready;
    assign game_in_rng = ({1'b0, game_addr} < CELLS_X);

    board_clear_seq #(
        .CELLS (CELLS),
        .ADDR_W(ADDR_W)
    ) u_clear_seq (
        .clk  (clk),
        .rst_n(rst_n),
        .start(clear_start),
        .grant(clr_slot),
        .busy (clr_busy),
        .done (clr_done),
        .addr (clr_addr)
    );

    // Stage p0: slot owner drives the RAM port and tags any read.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        tag_p0    = TAG_NONE;
        if (vga_slot) begin
            mem_en   = 1'b1;
            mem_addr = vga_addr;
            tag_p0   = TAG_VGA;
        end else if (clr_slot) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = clr_addr;
            mem_wdata = DATA_W'(EMPTY);
        end else if (game_acc) begin
            if (game_in_rng) begin
                mem_en    = 1'b1;
                mem_we    = game_we;
                mem_addr  = game_addr;
                mem_wdata = game_wdata;
                if (!game_we) tag_p0 = TAG_GAME;
            end else if (!game_we) begin
                tag_p0 = TAG_ERR;
            end
        end
    end

    always_comb begin
        tag_p1_d   = tag_p0;
        game_err_d = game_acc && !game_in_rng;
    end

    // Stage p1 -> p2: RAM data is valid now; steer it by tag.
    always_comb begin
        vga_data_d   = vga_data_q;
        vga_vld_d    = 1'b0;
        game_rdata_d = game_rdata_q;
        game_vld_d   = 1'b0;
        case (tag_p1_q)
            TAG_VGA: begin
                vga_data_d = mem_rdata;
                vga_vld_d  = 1'b1;
            end
            TAG_GAME: begin
                game_rdata_d = mem_rdata;
                game_vld_d   = 1'b1;
            end
            TAG_ERR: begin
                game_rdata_d = '0;
                game_vld_d   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_p1_q     <= TAG_NONE;
            game_err_q   <= 1'b0;
            vga_data_q   <= '0;
            vga_vld_q    <= 1'b0;
            game_rdata_q <= '0;
            game_vld_q   <= 1'b0;
        end else begin
            tag_p1_q     <= tag_p1_d;
            game_err_q   <= game_err_d;
            vga_data_q   <= vga_data_d;
            vga_vld_q    <= vga_vld_d;
            game_rdata_q <= game_rdata_d;
            game_vld_q   <= game_vld_d;
        end
    end

    assign vga_data       = vga_data_q;
    assign vga_data_valid = vga_vld_q;
    assign game_rdata     = game_rdata_q;
    assign game_rvalid    = game_vld_q;
    assign game_err       = game_err_q;
    assign clear_busy     = clr_busy;
    assign clear_done     = clr_done;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: RAM stub, queue-based reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_board_mem_arbiter;
    import gomoku_ui_pkg::*;

    localparam int NC = 225;
    localparam int AW = 8;
    localparam int DW = 2;

    logic          clk = 1'b0;
    logic          rst_n, pix_en, vga_req, game_valid, game_we, clear_start;
    logic [AW-1:0] vga_addr, game_addr, mem_addr;
    logic [DW-1:0] vga_data, game_wdata, game_rdata, mem_wdata;
    logic          vga_data_valid, game_ready, game_rvalid, game_err;
    logic          clear_busy, clear_done, mem_en, mem_we;
    logic [DW-1:0] mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int pcnt = 0;

    always #5 clk = ~clk;

    board_mem_arbiter #(.CELLS(NC), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .vga_req(vga_req),
        .vga_addr(vga_addr), .vga_data(vga_data), .vga_data_valid(vga_data_valid),
        .game_valid(game_valid), .game_ready(game_ready), .game_we(game_we),
        .game_addr(game_addr), .game_wdata(game_wdata), .game_rdata(game_rdata),
        .game_rvalid(game_rvalid), .game_err(game_err), .clear_start(clear_start),
        .clear_busy(clear_busy), .clear_done(clear_done), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port RAM with 1-cycle read latency.
    logic [DW-1:0] ram [256] = '{default: 2'b00};
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: board array, pending-response queue, clear pointer.
    typedef struct {
        int         due;
        bit         vga;
        logic [1:0] d;
    } rd_t;

    rd_t        rq[$];
    logic [1:0] ref_ram [256] = '{default: 2'b00};
    bit         m_clr = 0;
    int         m_ptr = 0;
    int         err_due = -1;
    logic [1:0] m_vdata = '0;
    logic [1:0] m_gdata = '0;

    always @(negedge clk) begin : model
        bit            m_vv, m_gv, e_en, e_we, e_done, e_ready, vs, new_err;
        logic [AW-1:0] e_addr;
        logic [1:0]    e_wd;
        cyc++;
        if (!rst_n) begin
            chk("rst_game_ready", game_ready, 0);
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_clear_busy", clear_busy, 0);
            chk("rst_clear_done", clear_done, 0);
            chk("rst_vga_data", vga_data, 0);
            chk("rst_vga_valid", vga_data_valid, 0);
            chk("rst_game_rdata", game_rdata, 0);
            chk("rst_game_rvalid", game_rvalid, 0);
            chk("rst_game_err", game_err, 0);
            rq.delete();
            m_clr = 0; m_ptr = 0; err_due = -1; m_vdata = '0; m_gdata = '0;
        end else begin
            m_vv = 0; m_gv = 0;
            while (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].vga) begin m_vdata = rq[0].d; m_vv = 1; end
                else           begin m_gdata = rq[0].d; m_gv = 1; end
                void'(rq.pop_front());
            end
            vs      = pix_en && vga_req;
            e_ready = !vs && !m_clr && !clear_start;
            e_en = 0; e_we = 0; e_addr = '0; e_wd = '0; e_done = 0; new_err = 0;
            if (vs) begin
                e_en = 1; e_addr = vga_addr;
                rq.push_back('{due: cyc + 2, vga: 1'b1, d: ref_ram[vga_addr]});
            end else if (m_clr) begin
                e_en = 1; e_we = 1; e_addr = AW'(m_ptr);
                ref_ram[m_ptr] = 2'b00;
                e_done = (m_ptr == NC - 1);
                m_ptr++;
            end else if (game_valid && e_ready) begin
                if (game_addr < NC) begin
                    e_en = 1; e_we = game_we; e_addr = game_addr; e_wd = game_wdata;
                    if (game_we) ref_ram[game_addr] = game_wdata;
                    else rq.push_back('{due: cyc + 2, vga: 1'b0, d: ref_ram[game_addr]});
                end else begin
                    new_err = 1;
                    if (!game_we) rq.push_back('{due: cyc + 2, vga: 1'b0, d: 2'b00});
                end
            end
            chk("game_ready", game_ready, e_ready);
            chk("mem_en", mem_en, e_en);
            chk("mem_we", mem_we, e_we);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_wdata", mem_wdata, e_wd);
            chk("clear_busy", clear_busy, m_clr);
            chk("clear_done", clear_done, e_done);
            chk("vga_data", vga_data, m_vdata);
            chk("vga_data_valid", vga_data_valid, m_vv);
            chk("game_rdata", game_rdata, m_gdata);
            chk("game_rvalid", game_rvalid, m_gv);
            chk("game_err", game_err, (err_due == cyc));
            if (new_err) err_due = cyc + 1;
            if (e_done) begin
                m_clr = 0; m_ptr = 0;
            end else if (!m_clr && clear_start) begin
                m_clr = 1; m_ptr = 0;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
        pcnt   = (pcnt + 1) % 4;
        pix_en = (pcnt == 0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int nwr, ndone, first_addr;
        rst_n = 0; pix_en = 0; vga_req = 1; vga_addr = 8'd17;
        game_valid = 1; game_we = 0; game_addr = 8'd5; game_wdata = '0; clear_start = 0;

        // Reset held with game_valid asserted.
        repeat (3) begin
            next();
            @(negedge clk);
            chk("lit_rst_ready", game_ready, 0);
            chk("lit_rst_mem_en", mem_en, 0);
        end
        next(); rst_n = 1; game_valid = 0; vga_req = 1;
        repeat (6) begin
            @(negedge clk);
            chk("lit_post_rst_ready", game_ready, pix_en ? 0 : 1);
            next();
        end
        vga_req = 0;

        // Write 17 = BLACK, read it back.
        game_valid = 1; game_we = 1; game_addr = 8'd17; game_wdata = 2'b01;
        @(negedge clk); chk("lit_wr_ready", game_ready, 1);
        next(); game_we = 0;
        @(negedge clk); chk("lit_rd_ready", game_ready, 1);
        next(); game_valid = 0;
        @(negedge clk); chk("lit_rd_t1_rvalid", game_rvalid, 0);
        next();
        @(negedge clk); chk("lit_rd_t2_rvalid", game_rvalid, 1);
        chk("lit_rd_t2_data", game_rdata, 2'b01);

        // VGA steals the slot from a waiting game read.
        while (pcnt != 3) next();
        next(); vga_req = 1; vga_addr = 8'd17; game_valid = 1; game_we = 0; game_addr = 8'd17;
        @(negedge clk); chk("lit_vga_ready", game_ready, 0); chk("lit_vga_addr", mem_addr, 17);
        next(); vga_req = 0;
        @(negedge clk); chk("lit_game_after_vga", game_ready, 1);
        next(); game_valid = 0;
        @(negedge clk); chk("lit_vga_valid", vga_data_valid, 1); chk("lit_vga_data", vga_data, 2'b01);
        next();
        @(negedge clk); chk("lit_game_valid2", game_rvalid, 1); chk("lit_game_data2", game_rdata, 2'b01);

        // Out-of-range game read.
        next(); game_valid = 1; game_we = 0; game_addr = 8'd230;
        @(negedge clk); chk("lit_oor_mem_en", mem_en, 0);
        next(); game_valid = 0;
        @(negedge clk); chk("lit_oor_err", game_err, 1);
        next();
        @(negedge clk); chk("lit_oor_rvalid", game_rvalid, 1); chk("lit_oor_rdata", game_rdata, 0);

        // Preload every cell WHITE.
        for (int a = 0; a < NC; a++) begin
            next(); game_valid = 1; game_we = 1; game_addr = AW'(a); game_wdata = 2'b10;
        end
        next(); game_valid = 0; vga_req = 1; vga_addr = AW'($urandom_range(0, NC - 1)); clear_start = 1;
        @(negedge clk); chk("lit_cs_ready", game_ready, 0);
        next(); clear_start = 0;
        nwr = 0; ndone = 0;
        for (int i = 0; i < 1000 && ndone == 0; i++) begin
            if (i > 0) begin next(); vga_addr = AW'($urandom_range(0, NC - 1)); end
            @(negedge clk);
            if (i == 0) chk("lit_clr_busy", clear_busy, 1);
            if (mem_en && mem_we) begin
                chk("lit_clr_addr", mem_addr, nwr);
                chk("lit_clr_not_vga", pix_en && vga_req, 0);
                nwr++;
            end
            if (clear_done) ndone++;
        end
        chk("lit_clr_writes", nwr, NC);
        chk("lit_clr_done_seen", ndone, 1);
        next(); vga_req = 0;
        @(negedge clk); chk("lit_clr_busy_after", clear_busy, 0); chk("lit_clr_done_once", clear_done, 0);
        game_valid = 1; game_we = 0; game_addr = 8'd100;
        next(); game_addr = 8'd224;
        next(); game_valid = 0;
        @(negedge clk); chk("lit_cleared_100", game_rdata, 2'b00); chk("lit_cleared_rv", game_rvalid, 1);
        next();
        @(negedge clk); chk("lit_cleared_224", game_rdata, 2'b00);

        // Reset in the middle of a clear, then restart.
        for (int a = 0; a < 8; a++) begin
            next(); game_valid = 1; game_we = 1; game_addr = AW'(a * 20); game_wdata = 2'b01;
        end
        next(); game_valid = 0; vga_req = 1; clear_start = 1;
        next(); clear_start = 0;
        nwr = 0;
        for (int i = 0; i < 500 && nwr < 101; i++) begin
            if (i > 0) next();
            @(negedge clk);
            if (mem_en && mem_we) nwr++;
        end
        chk("lit_mid_writes", nwr, 101);
        next(); rst_n = 0;
        @(negedge clk); chk("lit_mid_rst_busy", clear_busy, 0); chk("lit_mid_rst_done", clear_done, 0);
        next(); rst_n = 1; clear_start = 1;
        next(); clear_start = 0;
        first_addr = -1; ndone = 0;
        for (int i = 0; i < 1000 && ndone == 0; i++) begin
            if (i > 0) next();
            @(negedge clk);
            if (mem_en && mem_we && first_addr < 0) first_addr = mem_addr;
            if (clear_done) ndone++;
        end
        chk("lit_restart_addr0", first_addr, 0);
        chk("lit_restart_done", ndone, 1);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            next();
            rst_n       = ($urandom % 1500) != 0;
            vga_req     = $urandom % 2;
            vga_addr    = AW'($urandom_range(0, NC - 1));
            game_valid  = ($urandom % 4) != 0;
            game_we     = $urandom % 2;
            game_addr   = (($urandom % 8) == 0) ? AW'($urandom_range(NC, 255))
                                                : AW'($urandom_range(0, NC - 1));
            game_wdata  = DW'($urandom_range(0, 2));
            clear_start = ($urandom % 400) == 0;
        end
        next(); rst_n = 1; game_valid = 0; vga_req = 0; clear_start = 0;
        repeat (3) next();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Arbitrates the single-port board-state RAM (15x15 cells, 2 bits each) between two requesters:
  - the VGA pixel path, read-only, paced by the divide-by-4 pixel enable;
  - the game-logic port, read/write with a valid/ready handshake.
- Also sequences a full-board clear operation.
- Sits between the game FSM, the VGA pixel generator and the board RAM instance.

Parameters:
- CELLS, 225, number of board cells; legal addresses are 0..CELLS-1.
- ADDR_W, 8, address width; must satisfy 2**ADDR_W >= CELLS.
- DATA_W, 2, cell width; must match the package cell type.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- pix_en  in  1  single-cycle pulse, one cycle in every 4, from the VGA clock divider.
- vga_req  in  1  pixel generator needs a cell this pixel period; low during blanking.
- vga_addr  in  ADDR_W  cell address for the VGA read.
- vga_data  out  DATA_W  registered VGA read result, held until the next VGA read returns.
- vga_data_valid  out  1  one-cycle pulse when vga_data updates.
- game_valid  in  1  game request valid.
- game_ready  out  1  request accepted this cycle when valid && ready.
- game_we  in  1  1 = write, 0 = read.
- game_addr  in  ADDR_W  game cell address.
- game_wdata  in  DATA_W  write data.
- game_rdata  out  DATA_W  registered game read result.
- game_rvalid  out  1  one-cycle pulse with game_rdata.
- game_err  out  1  one-cycle pulse, 1 cycle after acceptance of an out-of-range address.
- clear_start  in  1  pulse; start clearing all cells to EMPTY.
- clear_busy  out  1  high while a clear is in progress.
- clear_done  out  1  one-cycle pulse after the last cell is written.
- mem_en, mem_we  out  1  RAM port controls.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; synchronous RAM with 1-cycle latency.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE; clear counter 0; read tag pipeline cleared.
  - All outputs 0: vga_data, game_rdata, every pulse output, mem_*, clear_busy.
- Slot owner per cycle is combinational. Priority, highest first:
  1. VGA: pix_en && vga_req.
  2. CLEAR: state CLEAR.
  3. GAME.
- VGA slot: mem_en=1, mem_we=0, mem_addr=vga_addr.
- vga_addr is not range-checked. Out-of-range addresses read whatever the RAM returns.
- CLEAR slot: mem_en=1, mem_we=1, mem_addr=clear counter, mem_wdata=EMPTY; the counter increments.
- game_ready = !(pix_en && vga_req) && state==IDLE.
  - Game is therefore guaranteed at least 3 of every 4 cycles while idle.
  - Game gets all cycles during blanking.
- Game accept, in range:
  - drives mem_en=1, mem_we=game_we, mem_addr/wdata from the game port, same cycle.
- Game accept, out of range (addr >= CELLS):
  - mem_en=0, no write.
  - game_err pulses in cycle T+1.
  - A read reports game_rvalid at T+2 with game_rdata=0.
- Read latency, for a VGA or game read issued in cycle T:
  - mem_rdata is valid in T+1 and is captured at the end of T+1.
  - vga_data/game_rdata update and the valid pulse is high in T+2.
  - Implement as a 2-stage tag pipeline (VGA/GAME/ERR).
- Writes produce no response pulse.
- Clear FSM: IDLE -> CLEAR on clear_start.
  - clear_start is ignored if already CLEAR.
  - clear_start beats game_valid in the same cycle; game_ready is 0 that cycle.
  - In CLEAR, the counter advances only on CLEAR-owned slots (VGA may steal cycles).
  - When the write to address CELLS-1 is issued, the FSM returns to IDLE and clear_done pulses in the same cycle.
  - A clear takes CELLS writes plus stolen VGA slots, roughly 300 cycles.
  - clear_busy = (state==CLEAR).
- VGA reads during a clear proceed normally; a partially cleared board may be displayed.
- Reset mid-clear aborts it with no clear_done. RAM contents are undefined/partial.
- Reset mid-read: in-flight results are discarded and no valid pulse is emitted.
- pix_en with vga_req=0: the slot goes to CLEAR or GAME as normal.
- Read-after-write to the same address: a read accepted after the write cycle sees the new data (single port, strictly ordered).

Decomposition:
- Shared package gomoku_ui_pkg holds:
  - cell_t enum: EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10.
  - BOARD_N=15, CELLS=BOARD_N*BOARD_N, ADDR_W.
  - tag enum for the read pipeline.
- One sub-module, board_clear_seq: IDLE/CLEAR FSM, address counter, busy/done; advanced by a grant input from the arbiter.

Test Plan:
- Reset with game_valid=1 held -> all outputs 0, game_ready=0; after release, game_ready=1 except in cycles with pix_en && vga_req.
- Game write addr 17 = BLACK (2'b01), then game read addr 17 -> game_rvalid exactly 2 cycles after read acceptance, game_rdata=2'b01.
- pix_en && vga_req with vga_addr 17 while game_valid is held -> game_ready=0 that cycle; vga_data_valid at T+2 with vga_data=2'b01; game is accepted the next cycle.
- Game read addr 230 -> game_err pulse at T+1, mem_en=0, game_rvalid at T+2 with data 0.
- Preload all cells WHITE, pulse clear_start with vga_req=1 -> clear_busy high; 225 writes with addresses 0..224 in order, none issued on VGA slots; clear_done single pulse; subsequent reads of any cell return 2'b00.
- Assert rst_n=0 at clear write 100 -> immediate clear_busy=0, no clear_done; a new clear after release restarts from address 0.
